// File: rtl/vga_scanout.sv
// Line-buffered VGA scanout. It fetches each upcoming line into a pixel FIFO during
// blanking and replays it against the timing inputs. Define VGA_SCANOUT_DOUBLE_EN for 2x horizontal doubling.
module vga_scanout #(
    parameter int          CORDW      = 11,
    parameter int          HA_END     = 1279,
    parameter int          VA_END     = 719,
    parameter int          SCREEN     = 740,
    parameter int          FIFO_DEPTH = 64,
    parameter logic [15:0] UFLOW_RGB  = 16'hF81F
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [CORDW-1:0] req_line,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [15:0]      pix_data,
    output logic [15:0]      rgb_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             underflow,
    output logic [1:0]       state_dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef VGA_SCANOUT_DOUBLE_EN
    localparam int LINE_WORDS = (HA_END + 1) / 2;
`else
    localparam int LINE_WORDS = HA_END + 1;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RECV = 2'd2} state_t;
    state_t state, state_nx;

    logic [CORDW-1:0] count, count_nx, req_line_nx, line_next, line_req;
    logic             line_end, trigger, pix_acc, push, pop, pop_slot;
    logic             fifo_full, fifo_empty;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level;
    logic [15:0]      pix_now, rgb_s1;
    logic             hs_s1, vs_s1, de_s1, vs_q;

    assign line_next = (sy == CORDW'(SCREEN)) ? '0 : sy + 1'b1;
    assign line_end  = (sx == CORDW'(HA_END + 1));
    assign trigger   = line_end && (line_next <= CORDW'(VA_END));

`ifdef VGA_SCANOUT_DOUBLE_EN
    logic phase;
    // Each word covers two de cycles; it is popped on the second one.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n)    phase <= 1'b0;
        else if (line_end) phase <= 1'b0;
        else if (de)       phase <= ~phase;
    end
    assign pop_slot = phase;
    assign line_req = line_next >> 1;
`else
    assign pop_slot = 1'b1;
    assign line_req = line_next;
`endif

    // Both handshakes transfer on a rising edge where valid && ready; the source
    // holds its payload stable while valid is high and ready is low.
    assign req_valid  = (state == REQ);
    assign pix_ready  = (state == RECV) && !fifo_full;
    assign pix_acc    = pix_valid && pix_ready;
    assign push       = pix_acc && !line_end;
    assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign pop        = de && !fifo_empty && pop_slot && !line_end;
    assign state_dbg  = state;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state    <= IDLE;
            count    <= '0;
            req_line <= '0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            req_line <= req_line_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        req_line_nx = req_line;
        case (state)
            IDLE: if (trigger) begin
                state_nx    = REQ;
                req_line_nx = line_req;
            end
            REQ: if (req_ready) begin
                state_nx = RECV;
                count_nx = '0;
            end
            RECV: if (pix_acc) begin
                if (count == CORDW'(LINE_WORDS - 1)) state_nx = IDLE;
                else                                 count_nx = count + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (push) mem[wr_ptr] <= pix_data;
    end

    // Leftovers from the previous line are discarded at the end of active video.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (line_end) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        pix_now = 16'h0000;
        if (de) pix_now = fifo_empty ? UFLOW_RGB : mem[rd_ptr];
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            rgb_s1  <= 16'h0000;
            hs_s1   <= 1'b1;
            vs_s1   <= 1'b1;
            de_s1   <= 1'b0;
            rgb_o   <= 16'h0000;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            de_o    <= 1'b0;
        end else begin
            rgb_s1  <= pix_now;
            hs_s1   <= hsync;
            vs_s1   <= vsync;
            de_s1   <= de;
            rgb_o   <= rgb_s1;
            hsync_o <= hs_s1;
            vsync_o <= vs_s1;
            de_o    <= de_s1;
        end
    end

    // Sticky until the frame sync starts; a missed line fetch also counts.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            vs_q      <= 1'b1;
            underflow <= 1'b0;
        end else begin
            vs_q <= vsync;
            if (vs_q && !vsync)
                underflow <= 1'b0;
            else if ((de && fifo_empty) || (trigger && state != IDLE))
                underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: drives 720p-style line timing, a line source
// and checks the video outputs against hand-derived expectations.
`timescale 1ns/1ps
module tb_vga_scanout;
    localparam int CORDW   = 11;
    localparam int HA_END  = 1279;
    localparam int VA_END  = 719;
    localparam int SCREEN  = 740;
    localparam int H_TOTAL = 1650;
    localparam logic [15:0] UFLOW = 16'hF81F;
`ifdef VGA_SCANOUT_DOUBLE_EN
    localparam int LINE_WORDS = 640;
    localparam int PPW        = 2;
`else
    localparam int LINE_WORDS = 1280;
    localparam int PPW        = 1;
`endif
    localparam int STALL_WORDS = 100;

    logic             clk_pix = 1'b0;
    logic             rst_pix_n;
    logic [CORDW-1:0] sx, sy;
    logic             hsync, vsync, de;
    logic             req_valid, req_ready;
    logic [CORDW-1:0] req_line;
    logic             pix_valid, pix_ready;
    logic [15:0]      pix_data, rgb_o;
    logic             hsync_o, vsync_o, de_o, underflow;
    logic [1:0]       state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int req_wait, src_limit, exp_supply;

    logic [15:0]      e1_rgb, e2_rgb;
    logic             e1_de, e2_de, e1_hs, e2_hs, e1_vs, e2_vs;
    int               e1_x, e2_x;
    int               line_errs, req_hold_cnt;
    logic [15:0]      line_rgb [HA_END+1];
    logic             pr_late;
    logic [1:0]       st_late;
    logic [CORDW-1:0] rl_late;
    bit               chk_req;

    vga_scanout dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
        .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
        .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .underflow(underflow), .state_dbg(state_dbg)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Line source: answers requests after req_wait cycles, then streams word index values.
    initial begin : source
        int idx, wait_cnt;
        bit acc_pend, hs_pend, streaming;
        idx = 0; wait_cnt = 0; acc_pend = 0; hs_pend = 0; streaming = 0;
        req_ready = 1'b0; pix_valid = 1'b0; pix_data = 16'h0;
        forever begin
            @(negedge clk_pix);
            if (acc_pend) idx++;
            if (hs_pend) begin streaming = 1; idx = 0; end
            acc_pend = 0; hs_pend = 0;
            if (!rst_pix_n) begin
                streaming = 0; wait_cnt = 0;
                req_ready = 1'b0; pix_valid = 1'b0;
            end else begin
                req_ready = 1'b0;
                if (req_valid) begin
                    if (wait_cnt < req_wait) wait_cnt++;
                    else begin
                        req_ready = 1'b1; hs_pend = 1; wait_cnt = 0; streaming = 0;
                    end
                end
                pix_valid = streaming && idx < src_limit && idx < LINE_WORDS;
                pix_data  = 16'(idx);
                acc_pend  = pix_valid && pix_ready;
            end
        end
    end

    task automatic blank_pipe();
        e1_rgb = 16'h0; e2_rgb = 16'h0; e1_de = 0; e2_de = 0;
        e1_hs = 1; e2_hs = 1; e1_vs = 1; e2_vs = 1; e1_x = 0; e2_x = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_pix);
        rst_pix_n = 1'b0;
        sx = '0; sy = '0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
        blank_pipe();
        repeat (3) @(negedge clk_pix);
        rst_pix_n = 1'b1;
    endtask

    task automatic drive_line(input int y, input int rst_at);
        logic [15:0] cur_rgb;
        int w;
        bit rel_pend;
        line_errs = 0; req_hold_cnt = 0; rel_pend = 0;
        for (int x = 0; x < H_TOTAL; x++) begin
            @(negedge clk_pix);
            if (rgb_o !== e2_rgb || de_o !== e2_de || hsync_o !== e2_hs || vsync_o !== e2_vs)
                line_errs++;
            if (e2_de) line_rgb[e2_x] = rgb_o;
            if (chk_req && x >= HA_END + 2 && x <= HA_END + 11 && req_valid && req_line == '0)
                req_hold_cnt++;
            if (x == HA_END + 5) rl_late = req_line;
            if (x == H_TOTAL - 50) begin pr_late = pix_ready; st_late = state_dbg; end
            sx    = CORDW'(x);
            sy    = CORDW'(y);
            de    = (x <= HA_END) && (y <= VA_END);
            hsync = !(x >= 1390 && x < 1430);
            vsync = !(y >= 725 && y < 730);
            w = x / PPW;
            cur_rgb = !de ? 16'h0 : (w < exp_supply) ? 16'(w) : UFLOW;
            e2_rgb = e1_rgb; e2_de = e1_de; e2_hs = e1_hs; e2_vs = e1_vs; e2_x = e1_x;
            e1_rgb = cur_rgb; e1_de = de; e1_hs = hsync; e1_vs = vsync; e1_x = x;
            if (rel_pend) begin #1 rst_pix_n = 1'b1; rel_pend = 0; end
            if (x == rst_at) begin
                check("pre_reset_state_recv", 32'(state_dbg), 2);
                #1 rst_pix_n = 1'b0;
                #1;
                check("rst_state_idle", 32'(state_dbg), 0);
                check("rst_req_valid", 32'(req_valid), 0);
                check("rst_pix_ready", 32'(pix_ready), 0);
                check("rst_req_line", 32'(req_line), 0);
                check("rst_underflow", 32'(underflow), 0);
                check("rst_rgb_o", 32'(rgb_o), 0);
                check("rst_de_o", 32'(de_o), 0);
                check("rst_hsync_o", 32'(hsync_o), 1);
                check("rst_vsync_o", 32'(vsync_o), 1);
                rel_pend = 1;
            end
        end
    endtask

    initial begin
        rst_pix_n = 1'b0;
        sx = '0; sy = '0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
        req_wait = 5; src_limit = LINE_WORDS; exp_supply = 0; chk_req = 0;
        pr_late = 1'b1; st_late = 2'd0; rl_late = '0;
        blank_pipe();
        repeat (3) @(negedge clk_pix);
        check("reset_req_valid", 32'(req_valid), 0);
        check("reset_pix_ready", 32'(pix_ready), 0);
        check("reset_req_line", 32'(req_line), 0);
        check("reset_underflow", 32'(underflow), 0);
        check("reset_rgb_o", 32'(rgb_o), 0);
        check("reset_de_o", 32'(de_o), 0);
        check("reset_hsync_o", 32'(hsync_o), 1);
        check("reset_vsync_o", 32'(vsync_o), 1);
        check("reset_state", 32'(state_dbg), 0);
        rst_pix_n = 1'b1;

        // First request from the last frame line, held through 5 stalled cycles; FIFO fills.
        chk_req = 1;
        drive_line(SCREEN, -1);
        chk_req = 0;
        check("req_hold_cycles", 32'(req_hold_cnt), 6);
        check("req_line_first", 32'(rl_late), 0);
        check("blank_fill_pix_ready", 32'(pr_late), 0);
        check("blank_fill_state", 32'(st_late), 2);
        check("l740_out_errs", 32'(line_errs), 0);

        req_wait = 2; exp_supply = LINE_WORDS;
        drive_line(0, -1);
        check("l0_out_errs", 32'(line_errs), 0);
        check("l0_pix0", 32'(line_rgb[0]), 0);
        check("l0_pix1", 32'(line_rgb[1]), 32'(1 / PPW));
        check("l0_pix2", 32'(line_rgb[2]), 32'(2 / PPW));
        check("l0_pix1279", 32'(line_rgb[1279]), 32'(1279 / PPW));
        check("l0_underflow", 32'(underflow), 0);
        check("l0_req_line", 32'(rl_late), 32'(1 / PPW));
        drive_line(1, -1);
        check("l1_out_errs", 32'(line_errs), 0);
        check("l1_pix3", 32'(line_rgb[3]), 32'(3 / PPW));
        check("l1_req_line", 32'(rl_late), 32'(2 / PPW));
        check("l1_underflow", 32'(underflow), 0);

        // Source stalls after 100 words.
        do_reset();
        src_limit = STALL_WORDS;
        drive_line(SCREEN, -1);
        exp_supply = STALL_WORDS;
        drive_line(0, -1);
        check("stall_out_errs", 32'(line_errs), 0);
        check("stall_last_good", 32'(line_rgb[STALL_WORDS*PPW-1]), 99);
        check("stall_first_bad", 32'(line_rgb[STALL_WORDS*PPW]), 32'(UFLOW));
        check("stall_end_pix", 32'(line_rgb[1279]), 32'(UFLOW));
        check("stall_underflow_set", 32'(underflow), 1);
        drive_line(724, -1);
        check("stall_underflow_held", 32'(underflow), 1);
        drive_line(725, -1);
        check("vsync_fall_clears", 32'(underflow), 0);
        check("l725_out_errs", 32'(line_errs), 0);

        // Reset in the middle of a fetch, then recovery at the next trigger.
        do_reset();
        src_limit = LINE_WORDS; exp_supply = LINE_WORDS;
        drive_line(SCREEN, -1);
        drive_line(0, -1);
        drive_line(1, 1300);
        check("rstmid_out_errs", 32'(line_errs), 0);
        check("rstmid_idle_after", 32'(state_dbg), 0);
        check("rstmid_no_req", 32'(req_valid), 0);
        exp_supply = 0;
        drive_line(2, -1);
        check("abandoned_out_errs", 32'(line_errs), 0);
        check("abandoned_pix0", 32'(line_rgb[0]), 32'(UFLOW));
        check("abandoned_underflow", 32'(underflow), 1);
        check("l2_req_line", 32'(rl_late), 32'(3 / PPW));
        exp_supply = LINE_WORDS;
        drive_line(3, -1);
        check("recover_out_errs", 32'(line_errs), 0);
        check("recover_pix5", 32'(line_rgb[5]), 32'(5 / PPW));
        check("recover_pix1279", 32'(line_rgb[1279]), 32'(1279 / PPW));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
